// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, colour types and the RRRGGGBB -> 24-bit expansion.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END   = HS_START + H_SYNC_DEF;
  localparam int VS_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END   = VS_START + V_SYNC_DEF;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Bit replication keeps full-scale codes at 8'hFF and zero at 8'h00.
  function automatic rgb888_t expand332(input rgb332_t c);
    rgb888_t o;
    o.r = {c.r, c.r, c.r[2:1]};
    o.g = {c.g, c.g, c.g[2:1]};
    o.b = {c.b, c.b, c.b, c.b};
    return o;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register with synchronous reset to RESET_VAL; DEPTH=0 is a wire.
module vga_sync_delay #(
  parameter int              WIDTH     = 3,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_s;
    assign unused_s = &{1'b0, clk, reset, en};
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift one stage per enable; reset refills every stage with RESET_VAL
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage_r[i] <= RESET_VAL;
      end else if (en) begin
        stage_r[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
      end
    end

    assign q = stage_r[DEPTH-1];
  end

endmodule

// File: rtl/vga_pixel_engine.sv
// VGA raster generator and colour back end: counters, sync decode, latency-matched
// timing delay and a shared output register for colour plus syncs.
module vga_pixel_engine
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int PIPE_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        sync_n
);

  localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC;

  if (HT >= 2048 || VT >= 2048 || PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_cfg_check
    $error("vga_pixel_engine: totals must be < 2048 and PIPE_LAT within 0..7");
  end

  logic [10:0] h_cnt_r, v_cnt_r;
  logic        h_last_s, v_last_s;
  logic        visible_s, hs_raw_s, vs_raw_s;
  logic [2:0]  tim_d_s;
  rgb888_t     rgb_r;
  logic        hsync_r, vsync_r, blank_r;

  assign h_last_s = (h_cnt_r == 11'(HT - 1));
  assign v_last_s = (v_cnt_r == 11'(VT - 1));

  // Raster counters: h wraps every line, v advances (and wraps) on the h wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_r <= 11'd0;
      v_cnt_r <= 11'd0;
    end else if (pix_en) begin
      if (h_last_s) begin
        h_cnt_r <= 11'd0;
        v_cnt_r <= v_last_s ? 11'd0 : v_cnt_r + 11'd1;
      end else begin
        h_cnt_r <= h_cnt_r + 11'd1;
      end
    end
  end

  // Undelayed timing decoded straight from the counters
  always_comb begin
    visible_s = 1'b0;
    hs_raw_s  = 1'b1;
    vs_raw_s  = 1'b1;
    if (h_cnt_r < 11'(H_ACTIVE) && v_cnt_r < 11'(V_ACTIVE)) begin
      visible_s = 1'b1;
    end else begin
      visible_s = 1'b0;
    end
    hs_raw_s = !(h_cnt_r >= 11'(HS_LO) && h_cnt_r < 11'(HS_HI));
    vs_raw_s = !(v_cnt_r >= 11'(VS_LO) && v_cnt_r < 11'(VS_HI));
  end

  vga_sync_delay #(
    .WIDTH     (3),
    .DEPTH     (PIPE_LAT),
    .RESET_VAL (3'b011)
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .d     ({visible_s, hs_raw_s, vs_raw_s}),
    .q     (tim_d_s)
  );

  // Output register: colour captured on the same tick as its delayed timing
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_r   <= rgb888_t'(24'h000000);
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
      blank_r <= 1'b0;
    end else if (pix_en) begin
      blank_r <= tim_d_s[2];
      hsync_r <= tim_d_s[1];
      vsync_r <= tim_d_s[0];
      rgb_r   <= tim_d_s[2] ? expand332(rgb332_t'(RGBIn)) : rgb888_t'(24'h000000);
    end
  end

  // Gated with reset so a reset cycle parked at the frame end never pulses
  assign startOfFrame = pix_en & ~reset & h_last_s & v_last_s;
  assign pixelX  = h_cnt_r;
  assign pixelY  = v_cnt_r;
  assign red     = rgb_r.r;
  assign green   = rgb_r.g;
  assign blue    = rgb_r.b;
  assign hsync   = hsync_r;
  assign vsync   = vsync_r;
  assign blank_n = blank_r;
  assign sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_pixel_engine.sv
// Scoreboard bench: three engine configurations share clk/reset/pix_en; per-tick expected
// outputs are queued by a raster model and popped by a monitor; directed checks run alongside.
module tb_vga_pixel_engine;

  typedef struct packed {
    logic        bn;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } exp_t;

  localparam exp_t FLUSH = '{bn: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 24'h000000};
  localparam logic [49:0] RST_VEC = {11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};

  logic clk = 1'b0;
  logic reset;
  logic pix_en;
  int   mode;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Independent colour expansion: 3-bit * 73 = xxx repeated thrice, 2-bit * 85 = xx repeated four times
  function automatic logic [23:0] exp_col(input logic [7:0] c);
    logic [8:0] r9, g9;
    logic [7:0] b8;
    r9 = 9'(c[7:5]) * 9'd73;
    g9 = 9'(c[4:2]) * 9'd73;
    b8 = 8'(c[1:0]) * 8'd85;
    return {r9[8:1], g9[8:1], b8};
  endfunction

  function automatic logic [7:0] mux_col(input logic [10:0] x, input int m);
    case (m)
      0:       return x[7:0];
      1:       return 8'hFF;
      default: return 8'hE0;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int HA  = (g == 2) ? 8 : 640;
    localparam int HF  = (g == 2) ? 2 : 16;
    localparam int HSY = (g == 2) ? 3 : 96;
    localparam int HB  = (g == 2) ? 2 : 48;
    localparam int VA  = (g == 2) ? 6 : 480;
    localparam int VF  = (g == 2) ? 1 : 10;
    localparam int VSY = 2;
    localparam int VB  = (g == 2) ? 1 : 33;
    localparam int LAT = (g == 1) ? 0 : 2;
    localparam int HT  = HA + HF + HSY + HB;
    localparam int VT  = VA + VF + VSY + VB;

    logic [10:0] px, py;
    logic        sof, hs, vs, bn, sn;
    logic [7:0]  r, gr, b, rgb_in;
    logic [7:0]  hist [8];
    exp_t        q[$];
    exp_t        e, last;
    logic [23:0] col;
    int          mx, my;
    bit          armed = 1'b0;
    bit          tick_seen = 1'b0;
    bit          vis;

    vga_pixel_engine #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .PIPE_LAT(LAT)
    ) dut (
      .clk(clk), .reset(reset), .pix_en(pix_en), .RGBIn(rgb_in),
      .pixelX(px), .pixelY(py), .startOfFrame(sof),
      .red(r), .green(gr), .blue(b),
      .hsync(hs), .vsync(vs), .blank_n(bn), .sync_n(sn)
    );

    // Object-mux model: colour of the presented pixel arrives LAT ticks later
    if (LAT == 0) begin : g_mux
      assign rgb_in = mux_col(px, mode);
    end else begin : g_mux
      assign rgb_in = hist[LAT-1];
    end

    initial forever begin
      @(posedge clk);
      if (pix_en === 1'b1 && reset === 1'b0) begin
        for (int i = 7; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= mux_col(px, mode);
      end
    end

    // Raster model: one expected output record per tick
    initial forever begin
      @(posedge clk);
      if (reset === 1'b1) begin
        q.delete();
        for (int i = 0; i < LAT; i++) q.push_back(FLUSH);
        mx = 0;
        my = 0;
        armed = 1'b1;
        tick_seen = 1'b0;
        last = FLUSH;
      end else if (armed && pix_en === 1'b1) begin
        vis  = (mx < HA) && (my < VA);
        e.bn = vis;
        e.hs = !(mx >= HA + HF && mx < HA + HF + HSY);
        e.vs = !(my >= VA + VF && my < VA + VF + VSY);
        case (mode)
          0:       col = exp_col(8'(mx));
          1:       col = 24'hFFFFFF;
          default: col = 24'hFF0000;
        endcase
        e.rgb = vis ? col : 24'h000000;
        q.push_back(e);
        if (mx == HT - 1) begin
          mx = 0;
          my = (my == VT - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
        tick_seen = 1'b1;
      end
    end

    // Monitor: pops on ticks, otherwise outputs must still show the last record
    initial forever begin
      @(negedge clk);
      if (armed) begin
        chk($sformatf("cfg%0d pixelX", g), 64'(px), 64'(mx));
        chk($sformatf("cfg%0d pixelY", g), 64'(py), 64'(my));
        chk($sformatf("cfg%0d startOfFrame", g), 64'(sof),
            64'(pix_en && !reset && mx == HT - 1 && my == VT - 1));
        chk($sformatf("cfg%0d sync_n", g), 64'(sn), 64'd0);
        if (tick_seen) begin
          tick_seen = 1'b0;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cfg%0d scoreboard: output tick with no expected record", g);
          end else begin
            last = q.pop_front();
          end
        end
        chk($sformatf("cfg%0d outputs{blank_n,hs,vs,rgb}", g),
            64'({bn, hs, vs, r, gr, b}), 64'(last));
      end
    end
  end

  task automatic rst_state_chk(input string tag);
    chk({tag, " cfg0"}, 64'({cfg[0].px, cfg[0].py, cfg[0].sof, cfg[0].bn, cfg[0].hs, cfg[0].vs,
                              cfg[0].r, cfg[0].gr, cfg[0].b}), 64'(RST_VEC));
    chk({tag, " cfg1"}, 64'({cfg[1].px, cfg[1].py, cfg[1].sof, cfg[1].bn, cfg[1].hs, cfg[1].vs,
                              cfg[1].r, cfg[1].gr, cfg[1].b}), 64'(RST_VEC));
    chk({tag, " cfg2"}, 64'({cfg[2].px, cfg[2].py, cfg[2].sof, cfg[2].bn, cfg[2].hs, cfg[2].vs,
                              cfg[2].r, cfg[2].gr, cfg[2].b}), 64'(RST_VEC));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first0, first1, low0, low1, nsof, nvs, nbn, p0, y0;
    reset  = 1'b1;
    pix_en = 1'b1;
    mode   = 0;
    repeat (3) step();
    reset = 1'b0;
    rst_state_chk("reset state");

    // Line sweep: stepping, line wrap, hsync window, colour alignment
    first0 = -1; first1 = -1; low0 = 0; low1 = 0;
    for (int t = 1; t <= 1600; t++) begin
      step();
      if (t <= 800) begin
        if (cfg[0].hs == 1'b0) begin
          if (first0 < 0) first0 = t;
          low0++;
        end
        if (cfg[1].hs == 1'b0) begin
          if (first1 < 0) first1 = t;
          low1++;
        end
      end
      case (t)
        2: begin
          chk("lat0 x1 blank_n", 64'(cfg[1].bn), 64'd1);
          chk("lat0 x1 colour", 64'({cfg[1].r, cfg[1].gr, cfg[1].b}), 64'h000055);
          chk("lat2 still flushing", 64'(cfg[0].bn), 64'd0);
        end
        3:   chk("lat2 first visible", 64'(cfg[0].bn), 64'd1);
        4:   chk("lat2 x1 colour", 64'({cfg[0].r, cfg[0].gr, cfg[0].b}), 64'h000055);
        230: chk("lat0 x229 colour", 64'({cfg[1].r, cfg[1].gr, cfg[1].b}), 64'hFF2455);
        232: chk("lat2 x229 colour", 64'({cfg[0].r, cfg[0].gr, cfg[0].b}), 64'hFF2455);
        799: chk("pixel (799,0)", 64'({cfg[0].py, cfg[0].px}), 64'({11'd0, 11'd799}));
        800: begin
          chk("pixel (0,1)", 64'({cfg[0].py, cfg[0].px}), 64'({11'd1, 11'd0}));
          chk("lat0 pixel (0,1)", 64'({cfg[1].py, cfg[1].px}), 64'({11'd1, 11'd0}));
          mode = 1;
        end
        813:  chk("FF -> white", 64'({cfg[0].r, cfg[0].gr, cfg[0].b}), 64'hFFFFFF);
        1443: chk("FF in h blank", 64'({cfg[0].bn, cfg[0].r, cfg[0].gr, cfg[0].b}), 64'd0);
        1441: chk("lat0 FF in h blank", 64'({cfg[1].bn, cfg[1].r, cfg[1].gr, cfg[1].b}), 64'd0);
        default: ;
      endcase
    end
    chk("lat2 hsync start", 64'(first0), 64'd659);
    chk("lat2 hsync width", 64'(low0), 64'd96);
    chk("lat0 hsync start", 64'(first1), 64'd657);
    chk("lat0 hsync width", 64'(low1), 64'd96);

    // One full small-raster frame: 15x10 with 8x6 visible, 2 sync lines
    mode = 2; nsof = 0; nvs = 0; nbn = 0;
    for (int k = 0; k < 150; k++) begin
      if (cfg[2].sof) nsof++;
      step();
      if (!cfg[2].vs) nvs++;
      if (cfg[2].bn) nbn++;
      if (k == 12) chk("E0 -> red", 64'({cfg[0].r, cfg[0].gr, cfg[0].b}), 64'hFF0000);
    end
    chk("frame startOfFrame clks", 64'(nsof), 64'd1);
    chk("frame vsync low ticks", 64'(nvs), 64'd30);
    chk("frame blank_n high ticks", 64'(nbn), 64'd48);

    // Half-rate pix_en: one line takes 1600 clocks
    mode = 0;
    p0 = int'(cfg[0].px);
    y0 = int'(cfg[0].py);
    for (int c = 0; c < 1600; c++) begin
      pix_en = (c % 2 == 0);
      step();
    end
    pix_en = 1'b1;
    chk("half-rate line pixelX", 64'(cfg[0].px), 64'(p0));
    chk("half-rate line pixelY", 64'(cfg[0].py), 64'(y0 + 1));

    // Mid-frame reset
    for (int i = 0; i < 200 && !(cfg[2].px == 11'd5 && cfg[2].py == 11'd3); i++) step();
    chk("reach small (5,3)", 64'({cfg[2].py, cfg[2].px}), 64'({11'd3, 11'd5}));
    reset = 1'b1;
    step();
    reset = 1'b0;
    rst_state_chk("midframe reset");
    nsof = 0;
    for (int k = 1; k <= 148; k++) begin
      step();
      if (cfg[2].sof) nsof++;
      if (k == 1) begin
        chk("post-reset lat0 visible", 64'(cfg[1].bn), 64'd1);
        chk("post-reset lat2 blank", 64'(cfg[0].bn), 64'd0);
      end
      if (k == 3) chk("post-reset lat2 visible", 64'(cfg[0].bn), 64'd1);
    end
    chk("no sof before first wrap", 64'(nsof), 64'd0);
    step();
    chk("sof at first wrap", 64'(cfg[2].sof), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
